// File: rtl/a2d_scan_sched.sv
// ---------------------------------------------------------------------------
// a2d_scan_sched
//
// Conversion scheduler in front of the SPI A2D interface. A period counter
// launches a round-robin scan of channels 0..NUM_CH-1 every SCAN_PERIOD
// clocks. Each result lands in a per-channel register. A single on-demand
// requester shares the converter, and its conversions are interleaved between
// scan slots.
//
// Parameters
//   NUM_CH       channels scanned (1..8); slot i converts channel i
//   SCAN_PERIOD  clocks between scan starts (>= 2)
//
// Ports
//   clk          system clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   en           enables periodic scanning
//   strt_cnv     one-cycle conversion start pulse to the A2D interface
//   chnnl        channel of the current conversion
//   cnv_cmplt    conversion-done pulse from the A2D interface
//   res          A2D result, valid with cnv_cmplt
//   ch_data      scan results, channel i at [12*i+11:12*i]
//   scan_done    one-cycle pulse when a full scan has been stored
//   scan_ovr     sticky: a period elapsed while the previous scan was pending
//   req_vld      on-demand conversion request
//   req_chnnl    requested channel
//   req_gnt      one-cycle pulse when the request is issued
//   req_rsp_vld  one-cycle pulse when req_rsp is updated
//   req_rsp      on-demand result, held until the next response
//
// Build option
//   A2D_SCAN_INVERT_EN  when defined, every stored value is ~res
// ---------------------------------------------------------------------------
module a2d_scan_sched #(
    parameter int NUM_CH      = 4,
    parameter int SCAN_PERIOD = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  strt_cnv,
    output logic [2:0]            chnnl,
    input  logic                  cnv_cmplt,
    input  logic [11:0]           res,
    output logic [12*NUM_CH-1:0]  ch_data,
    output logic                  scan_done,
    output logic                  scan_ovr,
    input  logic                  req_vld,
    input  logic [2:0]            req_chnnl,
    output logic                  req_gnt,
    output logic                  req_rsp_vld,
    output logic [11:0]           req_rsp
);

    localparam int             CW        = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_PERIOD - 1);
    localparam logic [2:0]     SLOT_LAST = 3'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        CAPT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    slot_q, slot_d;
    logic          scan_pend_q, scan_pend_d;
    logic          last_req_q, last_req_d;
    logic          cur_req_q, cur_req_d;      // conversion in flight is a request
    logic          strt_cnv_q, strt_cnv_d;
    logic [2:0]    chnnl_q, chnnl_d;
    logic          scan_done_q, scan_done_d;
    logic          scan_ovr_q, scan_ovr_d;
    logic          req_gnt_q, req_gnt_d;
    logic          req_rsp_vld_q, req_rsp_vld_d;
    logic [11:0]   req_rsp_q, req_rsp_d;

    logic          wrap;
    logic          ch_we;                     // store scan result into slot_q
    logic          scan_clr;                  // last slot of the scan stored
    logic [11:0]   cnv_val;

`ifdef A2D_SCAN_INVERT_EN
    // Light line on dark background reads high.
    assign cnv_val = ~res;
`else
    assign cnv_val = res;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        slot_d        = slot_q;
        scan_pend_d   = scan_pend_q;
        last_req_d    = last_req_q;
        cur_req_d     = cur_req_q;
        strt_cnv_d    = 1'b0;
        chnnl_d       = chnnl_q;
        scan_done_d   = 1'b0;
        scan_ovr_d    = scan_ovr_q;
        req_gnt_d     = 1'b0;
        req_rsp_vld_d = 1'b0;
        req_rsp_d     = req_rsp_q;
        ch_we         = 1'b0;
        scan_clr      = 1'b0;

        wrap = en && (cnt_q == CNT_LAST);

        // Period counter
        if (!en || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                // Scan wins when alone, or when the previous conversion was a
                // request; this caps requests at one per scan slot.
                if (scan_pend_q && (!req_vld || last_req_q)) begin
                    state_d    = ISSUE;
                    strt_cnv_d = 1'b1;
                    chnnl_d    = slot_q;
                    cur_req_d  = 1'b0;
                    last_req_d = 1'b0;
                end else if (req_vld) begin
                    state_d    = ISSUE;
                    strt_cnv_d = 1'b1;
                    chnnl_d    = req_chnnl;
                    req_gnt_d  = 1'b1;
                    cur_req_d  = 1'b1;
                    last_req_d = 1'b1;
                end
            end
            ISSUE: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (cnv_cmplt) begin
                    state_d = CAPT;
                    if (cur_req_q) begin
                        req_rsp_d     = cnv_val;
                        req_rsp_vld_d = 1'b1;
                    end else begin
                        ch_we = 1'b1;
                        if (slot_q == SLOT_LAST) begin
                            scan_done_d = 1'b1;
                            scan_clr    = 1'b1;
                            slot_d      = '0;
                        end else begin
                            slot_d = slot_q + 3'd1;
                        end
                    end
                end
            end
            CAPT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Scan-pending bookkeeping. A wrap while a scan is still pending
        // drops the new scan and flags the overrun instead.
        if (scan_clr) begin
            scan_pend_d = 1'b0;
        end
        if (!en) begin
            scan_pend_d = 1'b0;
        end else if (wrap) begin
            if (scan_pend_q) begin
                scan_ovr_d = 1'b1;
            end else begin
                scan_pend_d = 1'b1;
                slot_d      = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            slot_q        <= '0;
            scan_pend_q   <= 1'b0;
            last_req_q    <= 1'b0;
            cur_req_q     <= 1'b0;
            strt_cnv_q    <= 1'b0;
            chnnl_q       <= '0;
            scan_done_q   <= 1'b0;
            scan_ovr_q    <= 1'b0;
            req_gnt_q     <= 1'b0;
            req_rsp_vld_q <= 1'b0;
            req_rsp_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            scan_pend_q   <= scan_pend_d;
            last_req_q    <= last_req_d;
            cur_req_q     <= cur_req_d;
            strt_cnv_q    <= strt_cnv_d;
            chnnl_q       <= chnnl_d;
            scan_done_q   <= scan_done_d;
            scan_ovr_q    <= scan_ovr_d;
            req_gnt_q     <= req_gnt_d;
            req_rsp_vld_q <= req_rsp_vld_d;
            req_rsp_q     <= req_rsp_d;
        end
    end

    // Per-channel result registers
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [11:0] ch_q, ch_d;

            always_comb begin
                ch_d = ch_q;
                if (ch_we && (slot_q == 3'(gi))) begin
                    ch_d = cnv_val;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ch_q <= '0;
                end else begin
                    ch_q <= ch_d;
                end
            end

            assign ch_data[12*gi +: 12] = ch_q;
        end
    endgenerate

    assign strt_cnv    = strt_cnv_q;
    assign chnnl       = chnnl_q;
    assign scan_done   = scan_done_q;
    assign scan_ovr    = scan_ovr_q;
    assign req_gnt     = req_gnt_q;
    assign req_rsp_vld = req_rsp_vld_q;
    assign req_rsp     = req_rsp_q;

endmodule

// File: tb/tb_a2d_scan_sched.sv
// ---------------------------------------------------------------------------
// tb_a2d_scan_sched
//
// Directed bench for a2d_scan_sched (NUM_CH=4, SCAN_PERIOD=400). An A2D model
// answers each strt_cnv with cnv_cmplt after a programmable latency and
// res = res_base + channel. A monitor logs every issued conversion, every
// scan_done and every on-demand response with its cycle stamp.
// ---------------------------------------------------------------------------
module tb_a2d_scan_sched;

    localparam int NUM_CH = 4;
    localparam int PERIOD = 400;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic                 strt_cnv;
    logic [2:0]           chnnl;
    logic                 cnv_cmplt;
    logic [11:0]          res = 12'h000;
    logic [12*NUM_CH-1:0] ch_data;
    logic                 scan_done;
    logic                 scan_ovr;
    logic                 req_vld;
    logic [2:0]           req_chnnl;
    logic                 req_gnt;
    logic                 req_rsp_vld;
    logic [11:0]          req_rsp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    a2d_scan_sched #(
        .NUM_CH      (NUM_CH),
        .SCAN_PERIOD (PERIOD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .strt_cnv    (strt_cnv),
        .chnnl       (chnnl),
        .cnv_cmplt   (cnv_cmplt),
        .res         (res),
        .ch_data     (ch_data),
        .scan_done   (scan_done),
        .scan_ovr    (scan_ovr),
        .req_vld     (req_vld),
        .req_chnnl   (req_chnnl),
        .req_gnt     (req_gnt),
        .req_rsp_vld (req_rsp_vld),
        .req_rsp     (req_rsp)
    );

    // ---------------- A2D model (drives on negedge) ----------------
    int          lat      = 40;
    logic [11:0] res_base = 12'h100;
    int          m_cnt    = 0;
    logic        m_busy   = 1'b0;
    logic [2:0]  m_ch     = 3'd0;
    logic        model_cmplt = 1'b0;
    logic        spur     = 1'b0;

    assign cnv_cmplt = model_cmplt | spur;

    always @(negedge clk) begin
        model_cmplt = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                model_cmplt = 1'b1;
                res         = res_base + {9'd0, m_ch};
                m_busy      = 1'b0;
            end
        end else if (strt_cnv) begin
            m_busy = 1'b1;
            m_cnt  = lat;
            m_ch   = chnnl;
        end
    end

    // ---------------- Monitor ----------------
    int          cyc = 0;
    logic [2:0]  iss_ch[$];
    logic        iss_gnt[$];
    int          iss_t[$];
    int          done_t[$];
    logic [11:0] rsp_v[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (strt_cnv) begin
            iss_ch.push_back(chnnl);
            iss_gnt.push_back(req_gnt);
            iss_t.push_back(cyc);
            $display("[%0d] issue chnnl=%0d req_gnt=%0b", cyc, chnnl, req_gnt);
        end
        if (scan_done) begin
            done_t.push_back(cyc);
            $display("[%0d] scan_done ch_data=%h", cyc, ch_data);
        end
        if (req_rsp_vld) begin
            rsp_v.push_back(req_rsp);
            $display("[%0d] req_rsp=%h", cyc, req_rsp);
        end
    end

    // ---------------- Helpers ----------------
    function automatic logic [11:0] stored(input logic [11:0] v);
`ifdef A2D_SCAN_INVERT_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic wait_done(input int target, input int bound, input string tag);
        int n = 0;
        while (done_t.size() < target && n < bound) begin
            tick();
            n++;
        end
        if (done_t.size() < target) tmo(tag);
    endtask

    task automatic wait_iss(input int target, input int bound, input string tag);
        int n = 0;
        while (iss_ch.size() < target && n < bound) begin
            tick();
            n++;
        end
        if (iss_ch.size() < target) tmo(tag);
    endtask

    task automatic wait_strt(input logic want_ch1, input int bound, input string tag);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < bound) begin
            tick();
            n++;
            if (strt_cnv && (!want_ch1 || (chnnl == 3'd1 && !req_gnt))) hit = 1'b1;
        end
        if (!hit) tmo(tag);
    endtask

    // ---------------- Directed sequence ----------------
    initial begin
        int ib;
        int db;
        int rb;
        int cyc0;
        int n;
        int exp_seq[7];
        logic [47:0] exp_data;

        rst_n     = 1'b0;
        en        = 1'b0;
        req_vld   = 1'b0;
        req_chnnl = 3'd0;
        repeat (3) tick();

        // Reset state
        chk("rst_pulses", {strt_cnv, req_gnt, req_rsp_vld, scan_done, scan_ovr}, 0);
        chk("rst_chnnl", chnnl, 0);
        chk("rst_ch_data", ch_data, 0);
        chk("rst_req_rsp", req_rsp, 0);
        rst_n = 1'b1;
        tick();

        // Spurious cnv_cmplt in IDLE is ignored
        spur = 1'b1;
        tick();
        spur = 1'b0;
        repeat (5) tick();
        chk("spur_no_issue", iss_ch.size(), 0);
        chk("spur_no_rsp", rsp_v.size(), 0);
        chk("spur_ch_data", ch_data, 0);
        chk("spur_state", dut.state_q, 0);

        // Basic scan: wrap at 400 clocks after en, ISSUE one clock later,
        // each slot 43 clocks (40 + 3), scan_done after CAPT of slot 3.
        ib   = iss_ch.size();
        db   = done_t.size();
        cyc0 = cyc;
        en   = 1'b1;
        wait_done(db + 1, 1000, "basic_done");
        chk("basic_issue_cnt", iss_ch.size() - ib, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("basic_chnnl%0d", k), iss_ch[ib + k], k);
            chk($sformatf("basic_nognt%0d", k), iss_gnt[ib + k], 0);
        end
        chk("basic_first_issue", iss_t[ib] - cyc0, 401);
        chk("basic_issue_gap", iss_t[ib + 1] - iss_t[ib], 43);
        chk("basic_done_time", done_t[db] - cyc0, 571);
        exp_data = {stored(12'h103), stored(12'h102), stored(12'h101), stored(12'h100)};
        chk("basic_ch_data", ch_data, exp_data);
        wait_done(db + 2, 600, "basic_done2");
        chk("basic_period", done_t[db + 1] - done_t[db], PERIOD);
        chk("basic_no_ovr", scan_ovr, 0);

        // Interleave: request raised after slot 0 of the next scan issues
        wait_strt(1'b0, 600, "intl_start");
        req_vld   = 1'b1;
        req_chnnl = 3'd5;
        ib = iss_ch.size() - 1;
        rb = rsp_v.size();
        db = done_t.size();
        wait_iss(ib + 7, 1000, "intl_issues");
        req_vld = 1'b0;
        wait_done(db + 1, 1000, "intl_done");
        exp_seq = '{0, 5, 1, 5, 2, 5, 3};
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("intl_chnnl%0d", k), iss_ch[ib + k], exp_seq[k]);
            chk($sformatf("intl_gnt%0d", k), iss_gnt[ib + k], (exp_seq[k] == 5) ? 1 : 0);
        end
        chk("intl_rsp_cnt", rsp_v.size() - rb, 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("intl_rsp%0d", k), rsp_v[rb + k], stored(12'h105));
        end
        chk("intl_req_rsp_hold", req_rsp, stored(12'h105));
        chk("intl_ch_data", ch_data, exp_data);

        // Disable during slot 1: slot 1 stored (new base), slots 2-3 not issued
        wait_strt(1'b1, 600, "dis_slot1");
        en       = 1'b0;
        res_base = 12'h200;
        ib = iss_ch.size();
        db = done_t.size();
        repeat (200) tick();
        chk("dis_no_issue", iss_ch.size() - ib, 0);
        chk("dis_no_done", done_t.size() - db, 0);
        exp_data = {stored(12'h103), stored(12'h102), stored(12'h201), stored(12'h100)};
        chk("dis_ch_data", ch_data, exp_data);
        chk("dis_no_ovr", scan_ovr, 0);

        // Overrun: 4 x 103 clocks > 400, so the second wrap (clock 800) sees
        // the first scan still pending.
        res_base = 12'h100;
        lat      = 100;
        en       = 1'b1;
        n = 0;
        while (!scan_ovr && n < 1000) begin
            tick();
            n++;
        end
        chk("ovr_set_cycle", n, 800);
        repeat (300) tick();
        chk("ovr_sticky", scan_ovr, 1);

        // Reset while BUSY
        wait_strt(1'b0, 600, "rst_busy_start");
        repeat (5) tick();
        chk("rst_busy_pre", dut.state_q, 2);
        rst_n = 1'b0;
        en    = 1'b0;
        tick();
        chk("rstb_pulses", {strt_cnv, req_gnt, req_rsp_vld, scan_done, scan_ovr}, 0);
        chk("rstb_chnnl", chnnl, 0);
        chk("rstb_ch_data", ch_data, 0);
        chk("rstb_req_rsp", req_rsp, 0);
        chk("rstb_state", dut.state_q, 0);
        rst_n = 1'b1;
        ib = iss_ch.size();
        repeat (60) tick();
        chk("rstb_quiet", iss_ch.size() - ib, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/a2d_scan_sched.md
# a2d_scan_sched

Conversion scheduler in front of the SPI A2D interface. It periodically runs a round-robin scan of channels 0..NUM_CH-1 and stores each result in a per-channel register. It also shares the converter with one on-demand requester, interleaving single conversions between scan slots. It drives the A2D interface's `strt_cnv`/`chnnl` and consumes its `cnv_cmplt`/`res`.

## Interface
- `NUM_CH`, default 4: channels scanned, 1..8; slot i converts channel i.
- `SCAN_PERIOD`, default 50000: clocks between scan starts (1 ms at 50 MHz); must be ≥ 2.
- `clk` in 1: system clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: enables periodic scanning.
- `strt_cnv` out 1: one-cycle pulse that starts a conversion.
- `chnnl` out 3: channel of the current conversion.
- `cnv_cmplt` in 1: conversion-done pulse from the A2D interface.
- `res` in 12: A2D result, valid with `cnv_cmplt`.
- `ch_data` out 12*NUM_CH: scan results; channel i is at [12*i+11:12*i].
- `scan_done` out 1: one-cycle pulse when a full scan has been stored.
- `scan_ovr` out 1: sticky flag; a period elapsed while the previous scan was still pending.
- `req_vld` in 1: on-demand conversion request.
- `req_chnnl` in 3: requested channel.
- `req_gnt` out 1: one-cycle pulse when the request is issued.
- `req_rsp_vld` out 1: one-cycle pulse when `req_rsp` is valid.
- `req_rsp` out 12: on-demand result; holds until the next response.

## Operation
- **Period counter**
  - Runs 0..SCAN_PERIOD-1 while `en` is high, then wraps.
  - At the wrap it sets `scan_pend` and clears `slot` to 0.
  - If `scan_pend` is already set at the wrap, it sets `scan_ovr` and the new scan is dropped.
- **`en` low**
  - Counter held at 0 and `scan_pend` cleared.
  - An in-flight conversion completes and its result is stored.
  - Requests are still served.
- **FSM: IDLE → ISSUE → BUSY → CAPT → IDLE**
  - **IDLE** arbitrates between `scan_pend` and `req_vld`.
    - Only one candidate: it wins.
    - Both: alternate using the `last_req` flag. After a request conversion the scan wins; after a scan conversion the request wins. At most one request fits between consecutive scan slots, and a continuous requester cannot starve the scan.
    - Neither: stay in IDLE.
  - **ISSUE**
    - `strt_cnv`=1 for exactly one cycle.
    - `chnnl` = `slot` (scan) or the `req_chnnl` captured at arbitration (request).
    - `req_gnt`=1 in this cycle when a request won.
  - **BUSY**
    - Hold `chnnl` until `cnv_cmplt`.
    - `cnv_cmplt` is ignored in every state other than BUSY.
  - **CAPT** (one cycle) stores the result:
    - Scan: write `ch_data[slot]` and increment `slot`. If `slot` was NUM_CH-1: pulse `scan_done`, clear `scan_pend`, reset `slot` to 0.
    - Request: load `req_rsp` and pulse `req_rsp_vld`.
- **Requester protocol**
  - Hold `req_vld` and `req_chnnl` stable until `req_gnt`.
  - Drop `req_vld` the cycle after `req_gnt` unless a new request is wanted.
- **Reset:** all outputs and state return to reset values, including mid-conversion. The A2D interface shares `rst_n`, so no abort sequence is needed.
- **Reset values:**
  - `strt_cnv`, `req_gnt`, `req_rsp_vld`, `scan_done`, `scan_ovr` = 0.
  - `chnnl`=0, `ch_data`=0, `req_rsp`=0.
  - FSM=IDLE, counter=0, `slot`=0, `scan_pend`=0, `last_req`=0.

## Timing
- Arbitration decision in IDLE; `strt_cnv` asserts on the following cycle (ISSUE).
- `cnv_cmplt` sampled in BUSY at cycle t → results and pulses visible at t+1 (CAPT) → IDLE at t+2.
- Per conversion: issue-to-next-issue = A2D latency + 3 clocks.
- All outputs registered; no combinational path from inputs to outputs.
- `scan_done` and a `ch_data` write for the last slot occur in the same cycle.

## Configuration
- `A2D_SCAN_INVERT_EN`
  - Defined: every stored value (`ch_data` and `req_rsp`) is `~res`, the one's complement, so a light line on a dark background reads high.
  - Undefined: `res` is stored unmodified.

## Test plan
- **Basic scan:** NUM_CH=4, SCAN_PERIOD=400, `en`=1, A2D model returns 12'h100+chnnl after 40 clocks → `chnnl` sequence 0,1,2,3; `ch_data` = {12'h103,12'h102,12'h101,12'h100}; one `scan_done` pulse per 400 clocks.
- **Interleave:** `req_vld` held high with `req_chnnl`=5 during a scan → issue order 0,5,1,5,2,5,3. Each 5 gives `req_gnt`, then `req_rsp_vld` with `req_rsp`=12'h105.
- **Overrun:** SCAN_PERIOD=100 with 40-clock conversions → `scan_ovr` sets at the second wrap and stays 1 until `rst_n`=0.
- **Disable mid-scan:** drop `en` during slot 1 → slot 1 result is stored; slots 2–3 are not issued; no `scan_done`.
- **Spurious and reset:** `cnv_cmplt` pulsed in IDLE → no state change. `rst_n`=0 during BUSY → next clock all outputs at reset values and FSM in IDLE.
- **Invert macro:** with `A2D_SCAN_INVERT_EN` defined and `res`=12'h0F0 on ch0 → `ch_data[11:0]` = 12'hF0F.
